core_fetch: RTL and testbench
=============================

CORE_FETCH -- requirements
Module: core_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: output buffer entries and maximum in-flight requests.
REQ-003 clk_i  input  1: the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1: reset, asynchronous, active-high.
REQ-005 redirect_valid_i  input  1: branch, jump or trap redirect request.
REQ-006 redirect_pc_i  input  32: redirect target; bits [1:0] ignored and treated as 00.
REQ-007 imem_req_valid_o  output  1: fetch request valid.
REQ-008 imem_req_ready_i  input  1: memory accepts the request this cycle.
REQ-009 imem_addr_o  output  32: fetch address, word aligned.
REQ-010 imem_rsp_valid_i  input  1: response valid; responses return in request order.
REQ-011 imem_rsp_data_i  input  32: instruction word.
REQ-012 imem_rsp_err_i  input  1: access fault for this response.
REQ-013 fd_valid_o  output  1: instruction available to the decoder.
REQ-014 fd_ready_i  input  1: decoder consumes the instruction this cycle.
REQ-015 fd_instr_o  output  32: instruction, driven to the decoder instr_i.
REQ-016 fd_pc_o  output  32: PC of fd_instr_o, driven to the decoder pc_i.
REQ-017 fd_fault_o  output  1: instruction fetch access fault.

Function
REQ-018 Registers:
- fetch_pc: next address to request.
- rsp_pc: PC of the next accepted response.
- outstanding: 0..DEPTH.
- discard: 0..DEPTH.
- FIFO: DEPTH entries of {instr, pc, fault}.
REQ-019 Credit is defined as outstanding + fifo_count < DEPTH, using current registered values with no same-cycle pop bypass.
REQ-020 imem_req_valid_o shall equal credit AND NOT redirect_valid_i.
REQ-021 imem_addr_o shall equal fetch_pc.
REQ-022 While imem_req_valid_o is high and not accepted, imem_addr_o shall hold stable; a redirect is the only exception.
REQ-023 On request accept (imem_req_valid_o & imem_req_ready_i):
- fetch_pc += 4, wrapping modulo 2^32.
- outstanding increments.
REQ-024 On response with discard > 0:
- discard decrements.
- outstanding decrements.
- No FIFO push.
REQ-025 On response with discard = 0:
- Push {data, rsp_pc, err} into the FIFO.
- rsp_pc += 4.
- outstanding decrements.
REQ-026 A pushed entry with err = 1 shall store instr 32'h0000_0013 and fault = 1.
REQ-027 fd_valid_o = FIFO not empty; fd_* outputs reflect the head entry.
REQ-028 On fd_valid_o & fd_ready_i, the head entry is popped.
REQ-029 A push and a pop in the same cycle shall both take effect; the count is unchanged.
REQ-030 Minimum latency: the request is accepted in cycle N, the earliest response arrives in N+1, and fd_valid_o is high in N+2.
REQ-031 Redirect cycle (redirect_valid_i = 1):
- No request is issued.
- The FIFO is emptied, and a pop that cycle is ignored.
- fetch_pc and rsp_pc are loaded with {redirect_pc_i[31:2], 2'b00}.
- discard is loaded with outstanding minus (1 if a response arrives that cycle).
- A response arriving that cycle is dropped.
REQ-032 Redirect timing: the first request to the target is issued in the cycle after the redirect, and fd_valid_o is 0 in that cycle.
REQ-033 A redirect while discard > 0 shall reload discard per REQ-031; it shall never underflow.
REQ-034 A response arriving while outstanding = 0 is illegal: the bench shall flag it, and the RTL shall ignore it.
REQ-035 outstanding shall never exceed DEPTH, and fifo_count + outstanding shall never exceed DEPTH.

Reset
REQ-036 While rst_i = 1, the following shall apply immediately, regardless of clk_i:
- fetch_pc = rsp_pc = RESET_PC.
- outstanding = discard = 0.
- FIFO empty.
- fd_valid_o = 0, fd_fault_o = 0.
- fd_instr_o = 0, fd_pc_o = 0.
- imem_req_valid_o = 0.
REQ-037 Reset in the middle of an outstanding request discards all in-flight state; responses arriving after reset release count as illegal per REQ-034.
REQ-038 The first request after reset release shall be to RESET_PC, issued on the first clock edge with rst_i = 0.

Verification
REQ-039 Scenario: reset release, memory always ready, 1-cycle response latency, fd_ready_i = 1. Required response:
- Requests to 8000_0000, 8000_0004, 8000_0008, ...
- fd_pc_o follows the same sequence with data matching the request order.
REQ-040 Scenario: fd_ready_i = 0 for 10 cycles. Required response:
- Exactly 2 requests are issued, then imem_req_valid_o = 0.
- The FIFO holds 8000_0000 and 8000_0004.
- After fd_ready_i goes to 1, fetch resumes with 8000_0008 and no entry is lost or duplicated.
REQ-041 Scenario: 2 requests outstanding, redirect to 0000_1002. Required response:
- Both late responses are dropped.
- The next request is 0000_1000, and the next fd_pc_o is 0000_1000.
REQ-042 Scenario: redirect in the same cycle as a response with outstanding = 1. Required response:
- The response is dropped, and discard is 0.
- The following response is pushed with the target PC.
REQ-043 Scenario: imem_rsp_err_i = 1 on the response for 8000_0004. Required response:
- fd_fault_o = 1 with fd_instr_o = 0000_0013 and fd_pc_o = 8000_0004.
- The neighbouring entries have fault = 0.
REQ-044 Scenario: imem_req_ready_i held 0 for 5 cycles. Required response:
- imem_addr_o holds stable, and fetch_pc does not advance.
- rst_i asserted mid-stall clears all outputs at once.

Source files
------------

// File: rtl/core_fetch.sv
// Instruction fetch front end: issues word-aligned fetches under a credit limit, tracks
// in-flight responses, drops stale ones after a redirect, and buffers instructions for decode.
`timescale 1ns/1ps

module core_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   input  logic        imem_rsp_err_i,
   output logic        fd_valid_o,
   input  logic        fd_ready_i,
   output logic [31:0] fd_instr_o,
   output logic [31:0] fd_pc_o,
   output logic        fd_fault_o
);

   localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              CW       = $clog2(DEPTH + 1);
   localparam logic [CW:0]     DEPTH_W  = (CW + 1)'(DEPTH);
   localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
   localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

   logic [31:0]   fetch_pc_reg, fetch_pc_next;
   logic [31:0]   rsp_pc_reg, rsp_pc_next;
   logic [CW-1:0] outstanding_reg, outstanding_next;
   logic [CW-1:0] discard_reg, discard_next;
   logic [CW-1:0] count_reg, count_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;

   logic [31:0] instr_mem [DEPTH];
   logic [31:0] pc_mem    [DEPTH];
   logic        fault_mem [DEPTH];

   logic        credit;
   logic        req_valid;
   logic        req_fire;
   logic        rsp_fire;
   logic        push;
   logic        pop;
   logic        fifo_nonempty;
   logic [31:0] redirect_target;
   logic [31:0] push_instr;
   logic        unused_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign redirect_target = {redirect_pc_i[31:2], 2'b00};
   assign unused_bits     = ^redirect_pc_i[1:0];

   // Credit deliberately ignores a same-cycle pop so the request path stays short.
   assign credit        = ({1'b0, outstanding_reg} + {1'b0, count_reg}) < DEPTH_W;
   assign req_valid     = ~rst_i & credit & ~redirect_valid_i;
   assign req_fire      = req_valid & imem_req_ready_i;
   assign fifo_nonempty = (count_reg != '0);

   // A response with nothing outstanding cannot belong to any request and is ignored.
   assign rsp_fire   = imem_rsp_valid_i & (outstanding_reg != '0);
   assign push       = rsp_fire & (discard_reg == '0) & ~redirect_valid_i;
   assign pop        = fifo_nonempty & fd_ready_i & ~redirect_valid_i;
   assign push_instr = imem_rsp_err_i ? NOP_INSTR : imem_rsp_data_i;

   always_comb begin
      fetch_pc_next    = fetch_pc_reg;
      rsp_pc_next      = rsp_pc_reg;
      outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_fire);
      discard_next     = discard_reg;
      count_next       = count_reg;
      rd_ptr_next      = rd_ptr_reg;
      wr_ptr_next      = wr_ptr_reg;

      if (redirect_valid_i) begin
         // Everything still in flight belongs to the old path; discard it as it returns.
         fetch_pc_next = redirect_target;
         rsp_pc_next   = redirect_target;
         discard_next  = outstanding_reg - CW'(rsp_fire);
         count_next    = '0;
         rd_ptr_next   = wr_ptr_reg;
      end else begin
         if (req_fire) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
         end
         if (rsp_fire && (discard_reg != '0)) begin
            discard_next = discard_reg - CW'(1);
         end
         if (push) begin
            rsp_pc_next = rsp_pc_reg + 32'd4;
            wr_ptr_next = ptr_inc(wr_ptr_reg);
         end
         if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
         end
         count_next = count_reg + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc_reg    <= RESET_PC;
         rsp_pc_reg      <= RESET_PC;
         outstanding_reg <= '0;
         discard_reg     <= '0;
         count_reg       <= '0;
         rd_ptr_reg      <= '0;
         wr_ptr_reg      <= '0;
      end else begin
         fetch_pc_reg    <= fetch_pc_next;
         rsp_pc_reg      <= rsp_pc_next;
         outstanding_reg <= outstanding_next;
         discard_reg     <= discard_next;
         count_reg       <= count_next;
         rd_ptr_reg      <= rd_ptr_next;
         wr_ptr_reg      <= wr_ptr_next;
      end
   end

   // Entry storage needs no reset: occupancy is tracked by count_reg alone.
   always_ff @(posedge clk_i) begin
      if (push) begin
         instr_mem[wr_ptr_reg] <= push_instr;
         pc_mem[wr_ptr_reg]    <= rsp_pc_reg;
         fault_mem[wr_ptr_reg] <= imem_rsp_err_i;
      end
   end

   assign imem_req_valid_o = req_valid;
   assign imem_addr_o      = fetch_pc_reg;

   assign fd_valid_o = fifo_nonempty;
   assign fd_instr_o = fifo_nonempty ? instr_mem[rd_ptr_reg] : 32'h0;
   assign fd_pc_o    = fifo_nonempty ? pc_mem[rd_ptr_reg]    : 32'h0;
   assign fd_fault_o = fifo_nonempty & fault_mem[rd_ptr_reg];

endmodule

// File: tb/tb_core_fetch.sv
// Bench for core_fetch: queue-based epoch model checked every cycle, an in-order memory
// responder, and directed scenarios with hand-computed expectations.
`timescale 1ns/1ps

module tb_core_fetch;

   localparam logic [31:0] RPC   = 32'h8000_0000;
   localparam int          DEPTH = 2;

   typedef struct {
      logic [31:0] pc;
      int          epoch;
   } fl_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        redirect_valid_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i = 1'b1;
   logic [31:0] imem_addr_o;
   logic        imem_rsp_valid_i = 1'b0;
   logic [31:0] imem_rsp_data_i = 32'h0;
   logic        imem_rsp_err_i = 1'b0;
   logic        fd_valid_o;
   logic        fd_ready_i = 1'b1;
   logic [31:0] fd_instr_o;
   logic [31:0] fd_pc_o;
   logic        fd_fault_o;

   always #5 clk = ~clk;

   core_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_addr_o      (imem_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .imem_rsp_err_i   (imem_rsp_err_i),
      .fd_valid_o       (fd_valid_o),
      .fd_ready_i       (fd_ready_i),
      .fd_instr_o       (fd_instr_o),
      .fd_pc_o          (fd_pc_o),
      .fd_fault_o       (fd_fault_o)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   bit done   = 1'b0;

   // Model state: in-flight requests tagged with the path epoch they were issued on.
   fl_t         m_inflight[$];
   ent_t        m_fifo[$];
   logic [31:0] m_fetch_pc = RPC;
   int          m_epoch = 0;

   // Stimulus controls, applied just after each rising edge.
   logic        nx_rst = 1'b1;
   logic        nx_redirect = 1'b0;
   logic [31:0] nx_rpc = 32'h0;
   logic        nx_ready = 1'b1;
   logic        nx_fdr = 1'b1;
   logic        nx_rsp_en = 1'b1;
   logic        nx_stray = 1'b0;
   logic [31:0] err_addr = 32'h1;

   logic [31:0] mem_q[$];
   logic [31:0] acc_log[$];
   ent_t        pop_log[$];

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
      end
   endtask

   task automatic chk_acc(input int i, input logic [31:0] exp);
      if (acc_log.size() > i) chk($sformatf("req_seq[%0d]", i), acc_log[i], exp);
      else begin
         n_cmp++; n_fail++;
         $display("FAIL req_seq[%0d]: only %0d requests seen, expected %08h", i, acc_log.size(), exp);
      end
   endtask

   task automatic chk_pop(input int i, input logic [31:0] pc, input logic [31:0] instr, input logic fault);
      ent_t e;
      if (pop_log.size() > i) begin
         e = pop_log[i];
         chk($sformatf("pop_pc[%0d]", i), e.pc, pc);
         chk($sformatf("pop_instr[%0d]", i), e.instr, instr);
         chk($sformatf("pop_fault[%0d]", i), {31'h0, e.fault}, {31'h0, fault});
      end else begin
         n_cmp++; n_fail++;
         $display("FAIL pop_seq[%0d]: only %0d pops seen, expected pc %08h", i, pop_log.size(), pc);
      end
   endtask

   // Behavioural model, advanced on each rising edge from the inputs in force before it.
   always @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         m_inflight.delete();
         m_fifo.delete();
         m_fetch_pc = RPC;
         m_epoch    = 0;
      end else begin
         bit   acc, rsp, pop;
         fl_t  f;
         ent_t e;
         acc = ((m_inflight.size() + m_fifo.size()) < DEPTH) && !redirect_valid_i && imem_req_ready_i;
         rsp = imem_rsp_valid_i && (m_inflight.size() > 0);
         if (imem_rsp_valid_i && m_inflight.size() == 0)
            $display("note: illegal response at %0t with nothing outstanding (must be ignored)", $time);
         pop = (m_fifo.size() > 0) && fd_ready_i && !redirect_valid_i;
         if (pop) void'(m_fifo.pop_front());
         if (rsp) begin
            f = m_inflight.pop_front();
            if (!redirect_valid_i && f.epoch == m_epoch) begin
               e.pc    = f.pc;
               e.fault = imem_rsp_err_i;
               e.instr = imem_rsp_err_i ? 32'h0000_0013 : imem_rsp_data_i;
               m_fifo.push_back(e);
            end
         end
         if (redirect_valid_i) begin
            m_fifo.delete();
            m_epoch++;
            m_fetch_pc = {redirect_pc_i[31:2], 2'b00};
         end
         if (acc) begin
            f.pc    = m_fetch_pc;
            f.epoch = m_epoch;
            m_inflight.push_back(f);
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
   end

   // Cycle compare against the model, on the falling edge.
   always @(negedge clk) begin
      if (!done) begin
         bit m_req;
         m_req = !rst_i && ((m_inflight.size() + m_fifo.size()) < DEPTH) && !redirect_valid_i;
         chk("req_valid", {31'h0, imem_req_valid_o}, {31'h0, m_req});
         if (m_req) chk("req_addr", imem_addr_o, m_fetch_pc);
         chk("fd_valid", {31'h0, fd_valid_o}, {31'h0, m_fifo.size() > 0});
         if (m_fifo.size() > 0) begin
            chk("fd_pc", fd_pc_o, m_fifo[0].pc);
            chk("fd_instr", fd_instr_o, m_fifo[0].instr);
            chk("fd_fault", {31'h0, fd_fault_o}, {31'h0, m_fifo[0].fault});
         end else if (rst_i) begin
            chk("rst_fd_pc", fd_pc_o, 32'h0);
            chk("rst_fd_instr", fd_instr_o, 32'h0);
            chk("rst_fd_fault", {31'h0, fd_fault_o}, 32'h0);
         end
      end
   end

   // One clock cycle: drive inputs after the edge, then log handshakes at the falling edge.
   task automatic step();
      logic [31:0] a;
      ent_t        e;
      @(posedge clk);
      #1;
      rst_i            = nx_rst;
      redirect_valid_i = nx_redirect;
      redirect_pc_i    = nx_rpc;
      imem_req_ready_i = nx_ready;
      fd_ready_i       = nx_fdr;
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = 32'h0;
      imem_rsp_err_i   = 1'b0;
      if (nx_stray) begin
         imem_rsp_valid_i = 1'b1;
         imem_rsp_data_i  = 32'hBAD0_BAD0;
      end else if (nx_rsp_en && mem_q.size() > 0) begin
         a = mem_q.pop_front();
         imem_rsp_valid_i = 1'b1;
         imem_rsp_data_i  = mem_data(a);
         imem_rsp_err_i   = (a == err_addr);
      end
      @(negedge clk);
      if (imem_req_valid_o && imem_req_ready_i) begin
         mem_q.push_back(imem_addr_o);
         acc_log.push_back(imem_addr_o);
      end
      if (fd_valid_o && fd_ready_i && !redirect_valid_i) begin
         e.instr = fd_instr_o;
         e.pc    = fd_pc_o;
         e.fault = fd_fault_o;
         pop_log.push_back(e);
      end
   endtask

   task automatic do_reset();
      nx_rst = 1'b1;
      step();
      step();
      mem_q.delete();
      acc_log.delete();
      pop_log.delete();
      nx_rst = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_req_valid"}, {31'h0, imem_req_valid_o}, 32'h0);
      chk({tag, "_fd_valid"}, {31'h0, fd_valid_o}, 32'h0);
      chk({tag, "_fd_fault"}, {31'h0, fd_fault_o}, 32'h0);
      chk({tag, "_fd_instr"}, fd_instr_o, 32'h0);
      chk({tag, "_fd_pc"}, fd_pc_o, 32'h0);
   endtask

   initial begin
      // Asynchronous reset before any clock edge.
      #2 rst_i = 1'b1;
      #1 chk_outputs_zero("async_rst");

      // In-order streaming with an always-ready decoder.
      do_reset();
      step();
      chk("s1_req_valid0", {31'h0, imem_req_valid_o}, 32'h1);
      chk("s1_addr0", imem_addr_o, 32'h8000_0000);
      chk("s1_fd_valid0", {31'h0, fd_valid_o}, 32'h0);
      step();
      chk("s1_addr1", imem_addr_o, 32'h8000_0004);
      chk("s1_fd_valid1", {31'h0, fd_valid_o}, 32'h0);
      step();
      chk("s1_fd_valid2", {31'h0, fd_valid_o}, 32'h1);
      chk("s1_fd_pc2", fd_pc_o, 32'h8000_0000);
      chk("s1_fd_instr2", fd_instr_o, 32'h9234_5678);
      repeat (12) step();
      chk_acc(0, 32'h8000_0000);
      chk_acc(1, 32'h8000_0004);
      chk_acc(2, 32'h8000_0008);
      chk_acc(3, 32'h8000_000C);
      chk_pop(0, 32'h8000_0000, 32'h9234_5678, 1'b0);
      chk_pop(1, 32'h8000_0004, 32'h9234_567C, 1'b0);
      chk_pop(2, 32'h8000_0008, 32'h9234_5670, 1'b0);

      // Decoder stalled for 10 cycles: exactly two requests, then fetch stops.
      do_reset();
      nx_fdr = 1'b0;
      repeat (10) step();
      chk("s2_req_count", acc_log.size(), 32'd2);
      chk("s2_req_valid", {31'h0, imem_req_valid_o}, 32'h0);
      chk("s2_fd_pc_head", fd_pc_o, 32'h8000_0000);
      nx_fdr = 1'b1;
      repeat (12) step();
      chk_acc(2, 32'h8000_0008);
      chk_pop(0, 32'h8000_0000, 32'h9234_5678, 1'b0);
      chk_pop(1, 32'h8000_0004, 32'h9234_567C, 1'b0);
      chk_pop(2, 32'h8000_0008, 32'h9234_5670, 1'b0);
      chk_pop(3, 32'h8000_000C, 32'h9234_5674, 1'b0);

      // Redirect with two requests in flight; both late responses must vanish.
      do_reset();
      nx_rsp_en = 1'b0;
      repeat (3) step();
      chk("s3_req_count", acc_log.size(), 32'd2);
      chk("s3_req_blocked", {31'h0, imem_req_valid_o}, 32'h0);
      nx_redirect = 1'b1;
      nx_rpc      = 32'h0000_1002;
      step();
      chk("s3_redirect_req_valid", {31'h0, imem_req_valid_o}, 32'h0);
      nx_redirect = 1'b0;
      nx_rsp_en   = 1'b1;
      step();
      chk("s3_after_fd_valid", {31'h0, fd_valid_o}, 32'h0);
      repeat (8) step();
      chk_acc(2, 32'h0000_1000);
      chk_pop(0, 32'h0000_1000, 32'h1234_4678, 1'b0);

      // Redirect coinciding with the only outstanding response.
      do_reset();
      step();
      nx_redirect = 1'b1;
      nx_rpc      = 32'h0000_2000;
      step();
      chk("s4_redirect_req_valid", {31'h0, imem_req_valid_o}, 32'h0);
      nx_redirect = 1'b0;
      step();
      chk("s4_target_req_valid", {31'h0, imem_req_valid_o}, 32'h1);
      chk("s4_target_addr", imem_addr_o, 32'h0000_2000);
      chk("s4_target_fd_valid", {31'h0, fd_valid_o}, 32'h0);
      step();
      step();
      chk("s4_fd_valid", {31'h0, fd_valid_o}, 32'h1);
      chk("s4_fd_pc", fd_pc_o, 32'h0000_2000);
      chk("s4_fd_instr", fd_instr_o, 32'h1234_7678);

      // Access fault on the second word.
      do_reset();
      err_addr = 32'h8000_0004;
      repeat (10) step();
      err_addr = 32'h1;
      chk_pop(0, 32'h8000_0000, 32'h9234_5678, 1'b0);
      chk_pop(1, 32'h8000_0004, 32'h0000_0013, 1'b1);
      chk_pop(2, 32'h8000_0008, 32'h9234_5670, 1'b0);

      // Memory stall: address must hold, then reset lands mid-stall.
      do_reset();
      step();
      nx_ready = 1'b0;
      nx_fdr   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("s6_stall_valid%0d", i), {31'h0, imem_req_valid_o}, 32'h1);
         chk($sformatf("s6_stall_addr%0d", i), imem_addr_o, 32'h8000_0004);
      end
      chk("s6_req_count", acc_log.size(), 32'd1);
      chk("s6_fd_valid", {31'h0, fd_valid_o}, 32'h1);
      #2;
      nx_rst = 1'b1;
      rst_i  = 1'b1;
      #1 chk_outputs_zero("s6_mid_rst");
      mem_q.delete();
      nx_ready = 1'b1;
      nx_fdr   = 1'b1;

      // Stray response right after release must be ignored.
      do_reset();
      nx_stray = 1'b1;
      step();
      nx_stray = 1'b0;
      step();
      chk("s7_stray_fd_valid", {31'h0, fd_valid_o}, 32'h0);
      step();
      chk("s7_fd_valid", {31'h0, fd_valid_o}, 32'h1);
      chk("s7_fd_pc", fd_pc_o, 32'h8000_0000);
      chk("s7_fd_instr", fd_instr_o, 32'h9234_5678);
      repeat (4) step();

      done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
      $fatal(1);
   end

endmodule
